// File: rtl/hdmi_pixel_stream.sv
// Pixel stream to HDMI/DVI timing: counters, FWFT pixel FIFO and frame-lock FSM.
// Optional colour-bar generator enabled by defining PATTERN_GEN_EN.
module hdmi_pixel_stream #(
  parameter int COLOR_W    = 8,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int FIFO_DEPTH = 16,
  parameter int SYNC_POL   = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3*COLOR_W-1:0]   s_data,
  input  logic                   s_sof,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic                   clr_status,
`ifdef PATTERN_GEN_EN
  input  logic                   pattern_en,
`endif
  output logic [3*COLOR_W+2:0]   hdmi_tx_out,
  output logic                   underflow,
  output logic                   frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);
  localparam int PW      = 3 * COLOR_W;
  localparam int DW      = PW + 1;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam logic SYNC_LVL = (SYNC_POL != 0);

  typedef enum logic [1:0] {SYNC_WAIT = 2'd0, RUN = 2'd1, RESYNC = 2'd2} state_t;

  logic [HW-1:0] h_cnt_r;
  logic [VW-1:0] v_cnt_r;
  logic          de_s, hs_act_s, vs_act_s, origin_s;
  logic [DW-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [AW:0]   count_r;
  logic          full_s, empty_s, push_s, pop_s, uf_set_s;
  logic [DW-1:0] head_s;
  logic [PW-1:0] pix_s;
  state_t        state_r, state_nxt_s;
  logic [3*COLOR_W+2:0] tx_r;
  logic          underflow_r, frame_start_r;

  // Raster position counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_r <= '0;
      v_cnt_r <= '0;
    end else if (h_cnt_r == HW'(H_TOTAL - 1)) begin
      h_cnt_r <= '0;
      v_cnt_r <= (v_cnt_r == VW'(V_TOTAL - 1)) ? '0 : v_cnt_r + VW'(1);
    end else begin
      h_cnt_r <= h_cnt_r + HW'(1);
    end
  end

  assign de_s     = (h_cnt_r < HW'(H_ACTIVE)) && (v_cnt_r < VW'(V_ACTIVE));
  assign hs_act_s = (h_cnt_r >= HW'(H_ACTIVE + H_FP)) && (h_cnt_r < HW'(H_ACTIVE + H_FP + H_SYNC));
  assign vs_act_s = (v_cnt_r >= VW'(V_ACTIVE + V_FP)) && (v_cnt_r < VW'(V_ACTIVE + V_FP + V_SYNC));
  assign origin_s = (h_cnt_r == HW'(0)) && (v_cnt_r == VW'(0));

  assign full_s  = (count_r == (AW+1)'(FIFO_DEPTH));
  assign empty_s = (count_r == (AW+1)'(0));
  assign head_s  = mem_r[rd_ptr_r];
`ifdef PATTERN_GEN_EN
  assign s_ready = !full_s && !rst && !pattern_en;
`else
  assign s_ready = !full_s && !rst;
`endif
  assign push_s  = s_valid && s_ready;

  // FIFO storage; contents need no reset, pointers define validity
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {s_sof, s_data};
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      wr_ptr_r <= push_s ? wr_ptr_r + AW'(1) : wr_ptr_r;
      rd_ptr_r <= pop_s ? rd_ptr_r + AW'(1) : rd_ptr_r;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef PATTERN_GEN_EN
  logic [31:0] bar_idx_s;
  logic [2:0]  bar_rgb_s;
  assign bar_idx_s = 32'(h_cnt_r) / 32'(H_ACTIVE / 8);

  // Colour-bar lookup, bits are {R,G,B}
  always_comb begin
    case (bar_idx_s)
      32'd0:   bar_rgb_s = 3'b111;
      32'd1:   bar_rgb_s = 3'b110;
      32'd2:   bar_rgb_s = 3'b011;
      32'd3:   bar_rgb_s = 3'b010;
      32'd4:   bar_rgb_s = 3'b101;
      32'd5:   bar_rgb_s = 3'b100;
      32'd6:   bar_rgb_s = 3'b001;
      default: bar_rgb_s = 3'b000;
    endcase
  end
`endif

  // Frame-lock next state, FIFO pop and pixel selection
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    pix_s       = '0;
    uf_set_s    = 1'b0;
`ifdef PATTERN_GEN_EN
    if (pattern_en) begin
      state_nxt_s = SYNC_WAIT;
      pix_s = {{COLOR_W{bar_rgb_s[2]}}, {COLOR_W{bar_rgb_s[1]}}, {COLOR_W{bar_rgb_s[0]}}};
    end else
`endif
    begin
      case (state_r)
        SYNC_WAIT, RESYNC: begin
          // non-sof words are stale; a sof word waits for the raster origin
          if (empty_s) begin
            pop_s = 1'b0;
          end else if (!head_s[DW-1]) begin
            pop_s = 1'b1;
          end else if (origin_s) begin
            pop_s       = 1'b1;
            pix_s       = head_s[PW-1:0];
            state_nxt_s = RUN;
          end else begin
            pop_s = 1'b0;
          end
        end
        RUN: begin
          if (!de_s) begin
            pop_s = 1'b0;
          end else if (empty_s || (head_s[DW-1] && !origin_s)) begin
            uf_set_s    = 1'b1;
            state_nxt_s = RESYNC;
          end else begin
            pop_s = 1'b1;
            pix_s = head_s[PW-1:0];
          end
        end
        default: state_nxt_s = SYNC_WAIT;
      endcase
    end
  end

  // State, registered video output and status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= SYNC_WAIT;
      tx_r          <= {{PW{1'b0}}, 1'b0, ~SYNC_LVL, ~SYNC_LVL};
      underflow_r   <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      tx_r          <= {de_s ? pix_s : {PW{1'b0}}, de_s,
                        hs_act_s ? SYNC_LVL : ~SYNC_LVL,
                        vs_act_s ? SYNC_LVL : ~SYNC_LVL};
      underflow_r   <= uf_set_s ? 1'b1 : (clr_status ? 1'b0 : underflow_r);
      frame_start_r <= origin_s;
    end
  end

  assign hdmi_tx_out = tx_r;
  assign underflow   = underflow_r;
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_hdmi_pixel_stream.sv
// Randomised bench for hdmi_pixel_stream on a reduced raster, checked against a
// queue-based reference model of the frame-lock rules.
module tb_hdmi_pixel_stream;
  localparam int CW = 8;
  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 6, VF = 1, VS = 2, VB = 1;
  localparam int DEPTH = 16;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int PW = 3 * CW;
  localparam int TW = PW + 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [PW-1:0] s_data = '0;
  logic          s_sof = 1'b0, s_valid = 1'b0, clr_status = 1'b0, pattern_en = 1'b0;
  logic          s_ready, underflow, frame_start;
  logic [TW-1:0] hdmi_tx_out;

  always #5 clk = ~clk;

  hdmi_pixel_stream #(
    .COLOR_W(CW), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .FIFO_DEPTH(DEPTH), .SYNC_POL(0)
  ) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_sof(s_sof), .s_valid(s_valid),
    .s_ready(s_ready), .clr_status(clr_status),
`ifdef PATTERN_GEN_EN
    .pattern_en(pattern_en),
`endif
    .hdmi_tx_out(hdmi_tx_out), .underflow(underflow), .frame_start(frame_start)
  );

  int vectors = 0, miscompares = 0;
  int mh = 0, mv = 0;
  bit locked = 1'b0, exp_uf = 1'b0, chk_xy = 1'b0;
  logic [PW:0] q[$];
  int de_cnt = 0, hs_low = 0, vs_low = 0, fs_cnt = 0, pix_nz = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] xy_word(input int x, input int y);
    logic [7:0] xb, yb;
    xb = 8'(x);
    yb = 8'(y);
    return {yb, xb, 8'hFA};
  endfunction

  function automatic logic [PW-1:0] bar(input int x);
    logic [2:0] c;
    case (x / (HA / 8))
      0: c = 3'b111;  1: c = 3'b110;  2: c = 3'b011;  3: c = 3'b010;
      4: c = 3'b101;  5: c = 3'b100;  6: c = 3'b001;  default: c = 3'b000;
    endcase
    return {{CW{c[2]}}, {CW{c[1]}}, {CW{c[0]}}};
  endfunction

  // One clock: check s_ready, advance the model, then compare registered outputs.
  task automatic cycle();
    bit rdy, de, org, hs, vs, ufs;
    logic [PW-1:0] pix;
    logic [PW:0]   w;
    logic [TW-1:0] ex;
    int x, y;
    rdy = (q.size() < DEPTH) && !pattern_en;
    @(negedge clk);
    check("s_ready", s_ready, rdy);
    @(posedge clk);
    x = mh; y = mv;
    de  = (x < HA) && (y < VA);
    org = (x == 0) && (y == 0);
    hs  = (x >= HA + HF) && (x < HA + HF + HS);
    vs  = (y >= VA + VF) && (y < VA + VF + VS);
    pix = '0; ufs = 1'b0;
    if (pattern_en) begin
      locked = 1'b0;
      if (de) pix = bar(x);
    end else if (!locked) begin
      if (q.size() > 0) begin
        if (q[0][PW] == 1'b0) void'(q.pop_front());
        else if (org) begin
          w = q.pop_front(); pix = w[PW-1:0]; locked = 1'b1;
        end
      end
    end else if (de) begin
      if (q.size() == 0 || (q[0][PW] && !org)) begin
        ufs = 1'b1; locked = 1'b0;
      end else begin
        w = q.pop_front(); pix = w[PW-1:0];
      end
    end
    if (s_valid && rdy) q.push_back({s_sof, s_data});
    exp_uf = ufs ? 1'b1 : (clr_status ? 1'b0 : exp_uf);
    mh = (x + 1) % HT;
    if (x == HT - 1) mv = (y + 1) % VT;
    #1;
    ex = {de ? pix : {PW{1'b0}}, de, ~hs, ~vs};
    check("hdmi_tx_out", hdmi_tx_out, ex);
    check("underflow", underflow, exp_uf);
    check("frame_start", frame_start, org);
    if (chk_xy && hdmi_tx_out[2] && hdmi_tx_out[TW-1:3] != '0)
      check("pixel_xy", hdmi_tx_out[TW-1:3], xy_word(x, y));
    de_cnt += int'(hdmi_tx_out[2]);
    hs_low += int'(!hdmi_tx_out[1]);
    vs_low += int'(!hdmi_tx_out[0]);
    fs_cnt += int'(frame_start);
    pix_nz += int'(hdmi_tx_out[TW-1:3] != '0);
  endtask

  task automatic hit_reset();
    rst = 1'b1; s_valid = 1'b0; s_sof = 1'b0; clr_status = 1'b0;
    #1;
    check("rst_tx", hdmi_tx_out, 32'h3);
    check("rst_uf", underflow, 1'b0);
    check("rst_fs", frame_start, 1'b0);
    check("rst_ready", s_ready, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mh = 0; mv = 0; locked = 1'b0; exp_uf = 1'b0; q.delete();
  endtask

  task automatic run_until(input int h, input int v);
    int guard;
    guard = 0;
    while (!(mh == h && mv == v) && guard < 2000) begin
      cycle();
      guard++;
    end
    check("run_until_bound", 32'(guard < 2000), 1'b1);
  endtask

  task automatic stream(input int npix, input int pct, input int bad_idx);
    for (int i = 0; i < npix; i++) begin
      int x, y, tries;
      bit acc;
      x = i % HA; y = (i / HA) % VA; tries = 0;
      do begin
        s_valid = ($urandom_range(0, 99) < pct);
        s_data  = xy_word(x, y);
        s_sof   = ((i % (HA * VA)) == 0) || (i == bad_idx);
        acc     = s_valid && (q.size() < DEPTH) && !pattern_en;
        cycle();
        tries++;
      end while (!acc && tries < 1000);
      check("stream_accept", 32'(acc), 1'b1);
      if (!acc) i = npix;
    end
    s_valid = 1'b0; s_sof = 1'b0;
  endtask

  initial begin
    #1;
    hit_reset();

    // idle raster: timing shape with no input
    de_cnt = 0; hs_low = 0; vs_low = 0; fs_cnt = 0; pix_nz = 0;
    repeat (HT * VT) cycle();
    check("idle_de", de_cnt, HA * VA);
    check("idle_hsync", hs_low, HS * VT);
    check("idle_vsync", vs_low, VS * HT);
    check("idle_fs", fs_cnt, 1);
    check("idle_pix", pix_nz, 0);
    check("idle_uf", underflow, 1'b0);

    // two frames streamed from mid-frame; lock on the next origin
    repeat (37) cycle();
    chk_xy = 1'b1;
    stream(2 * HA * VA, 90, -1);
    check("stream_uf", underflow, 1'b0);

    // input stops: underflow at the next origin, black afterwards
    run_until(0, 0);
    cycle();
    check("uf_at_origin", underflow, 1'b1);
    repeat (3 * HT) cycle();
    clr_status = 1'b1;
    cycle();
    clr_status = 1'b0;
    check("uf_clear", underflow, 1'b0);

    // resume with sof, drain, underflow again
    stream(HA * VA, 90, -1);
    check("resume_uf", underflow, 1'b0);
    repeat (HT * VT) cycle();
    check("drain_uf", underflow, 1'b1);

    // asynchronous reset mid-line
    run_until(10, 2);
    hit_reset();

    // misplaced sof inside a locked frame
    chk_xy = 1'b0;
    stream(HA * VA, 100, 20);
    repeat (HT * VT) cycle();
    check("misalign_uf", underflow, 1'b1);

    // FIFO fills while waiting for origin; space reopens after the first pop
    hit_reset();
    repeat (30) cycle();
    for (int i = 0; i < DEPTH; i++) begin
      s_valid = 1'b1; s_sof = (i == 0); s_data = xy_word(i, 0);
      cycle();
    end
    s_sof = 1'b0;
    check("full_ready", s_ready, 1'b0);
    run_until(0, 0);
    cycle();
    check("refill_ready", s_ready, 1'b1);
    s_valid = 1'b0;
    repeat (HT * 2) cycle();

`ifdef PATTERN_GEN_EN
    hit_reset();
    pattern_en = 1'b1; s_valid = 1'b1;
    run_until(0, 1);
    cycle();
    check("pat_white", hdmi_tx_out[TW-1:3], 24'hFFFFFF);
    check("pat_ready", s_ready, 1'b0);
    run_until(HA - 1, 1);
    cycle();
    check("pat_black", hdmi_tx_out[TW-1:2], 32'h1);
    repeat (HT * VT) cycle();
    pattern_en = 1'b0; s_valid = 1'b0;
    repeat (HT) cycle();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
